// File: rtl/axis_frame_source_pkg.sv
// Shared types and helpers for the AXI-stream frame source.
package axis_frame_source_pkg;

  // Frame generator states: waiting for a command, offering a beat, idling between beats.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Data generation mode for the beats of one frame.
  typedef enum logic {
    MODE_INC   = 1'b0,
    MODE_CONST = 1'b1
  } mode_t;

  // Number of byte lanes (tkeep width) for a given tdata width.
  function automatic int keepw(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/axis_frame_source_if.sv
// Command port and AXI-stream master port of the frame source, bundled.
// master = the frame source itself, slave = whoever issues commands and sinks the stream.
interface axis_frame_source_if
  import axis_frame_source_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int LENWIDTH = 16,
  parameter int GAPWIDTH = 4
);

  localparam int KW = keepw(DWIDTH);

  // Command handshake
  logic                cmd_valid;
  logic                cmd_ready;
  logic [LENWIDTH-1:0] cmd_len;
  logic [DWIDTH-1:0]   cmd_seed;
  logic                cmd_mode;
  logic [GAPWIDTH-1:0] cmd_gap;
  logic [KW-1:0]       cmd_last_keep;

  // AXI-stream master
  logic [DWIDTH-1:0]   m_tdata;
  logic [KW-1:0]       m_tkeep;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready;

  modport master (
    input  cmd_valid, cmd_len, cmd_seed, cmd_mode, cmd_gap, cmd_last_keep,
    output cmd_ready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid,
    input  m_tready
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_seed, cmd_mode, cmd_gap, cmd_last_keep,
    input  cmd_ready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid,
    output m_tready
  );

endinterface

// File: rtl/axis_src_stats.sv
// Traffic statistics: completed-frame counter (wraps) and stall-cycle counter (saturates).
module axis_src_stats (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        frame_done,
  input  logic        stall,
  output logic [31:0] frames_sent,
  output logic [31:0] stall_cycles
);

  logic [31:0] r_frames;
  logic [31:0] r_stalls;

  // Count completed frames (free-running wrap) and stalled cycles (stick at all-ones).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_frames <= '0;
      r_stalls <= '0;
    end else begin
      if (frame_done) begin
        r_frames <= r_frames + 32'd1;
      end
      if (stall && (r_stalls != '1)) begin
        r_stalls <= r_stalls + 32'd1;
      end
    end
  end

  assign frames_sent  = r_frames;
  assign stall_cycles = r_stalls;

endmodule

// File: rtl/axis_frame_source.sv
// AXI-stream frame source: takes one frame command at a time and emits cmd_len beats of
// incrementing or constant data, tlast on the final beat, optional idle gap between beats.
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int LENWIDTH = 16,
  parameter int GAPWIDTH = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_frame_source_if.master  bus,
  output logic                 busy,
  output logic                 zero_len_pulse,
  output logic [31:0]          frames_sent,
  output logic [31:0]          stall_cycles
);

  localparam int KW = keepw(DWIDTH);

  localparam logic [LENWIDTH-1:0] LEN_ONE  = 1;
  localparam logic [DWIDTH-1:0]   DATA_ONE = 1;
  localparam logic [GAPWIDTH-1:0] GAP_ONE  = 1;

  state_t              r_state;
  state_t              w_state_next;

  logic [LENWIDTH-1:0] r_len,       w_len_next;
  logic [LENWIDTH-1:0] r_beat_idx,  w_beat_idx_next;
  logic [DWIDTH-1:0]   r_data,      w_data_next;
  mode_t               r_mode,      w_mode_next;
  logic [GAPWIDTH-1:0] r_gap,       w_gap_next;
  logic [GAPWIDTH-1:0] r_gap_cnt,   w_gap_cnt_next;
  logic [KW-1:0]       r_last_keep, w_last_keep_next;
  logic [KW-1:0]       r_tkeep,     w_tkeep_next;
  logic                r_tlast,     w_tlast_next;
  logic                r_zero_pulse, w_zero_pulse_next;

  logic                w_cmd_fire;
  logic                w_beat_fire;
  logic                w_frame_done;
  logic                w_stall;
  logic [LENWIDTH-1:0] w_idx_inc;
  logic                w_next_is_last;

  // Handshake qualifiers; commands are only seen in IDLE, tready only while a beat is offered.
  assign w_cmd_fire     = (r_state == IDLE) && bus.cmd_valid;
  assign w_beat_fire    = (r_state == SEND) && bus.m_tready;
  assign w_frame_done   = w_beat_fire && r_tlast;
  assign w_stall        = (r_state == SEND) && !bus.m_tready;
  assign w_idx_inc      = r_beat_idx + LEN_ONE;
  assign w_next_is_last = (w_idx_inc == (r_len - LEN_ONE));

  // Next-state and next-beat computation; every target defaults to holding its value.
  always_comb begin
    w_state_next      = r_state;
    w_len_next        = r_len;
    w_beat_idx_next   = r_beat_idx;
    w_data_next       = r_data;
    w_mode_next       = r_mode;
    w_gap_next        = r_gap;
    w_gap_cnt_next    = r_gap_cnt;
    w_last_keep_next  = r_last_keep;
    w_tkeep_next      = r_tkeep;
    w_tlast_next      = r_tlast;
    w_zero_pulse_next = w_cmd_fire && (bus.cmd_len == '0);

    case (r_state)
      IDLE: begin
        if (w_cmd_fire && (bus.cmd_len != '0)) begin
          w_state_next     = SEND;
          w_len_next       = bus.cmd_len;
          w_beat_idx_next  = '0;
          w_data_next      = bus.cmd_seed;
          w_mode_next      = mode_t'(bus.cmd_mode);
          w_gap_next       = bus.cmd_gap;
          w_last_keep_next = bus.cmd_last_keep;
          // A one-beat frame starts on its last beat.
          w_tlast_next     = (bus.cmd_len == LEN_ONE);
          w_tkeep_next     = (bus.cmd_len == LEN_ONE) ? bus.cmd_last_keep : '1;
        end
      end

      SEND: begin
        if (w_beat_fire) begin
          if (r_tlast) begin
            w_state_next = IDLE;
            w_tlast_next = 1'b0;
            w_tkeep_next = '0;
          end else begin
            w_beat_idx_next = w_idx_inc;
            w_data_next     = (r_mode == MODE_INC) ? (r_data + DATA_ONE) : r_data;
            w_tlast_next    = w_next_is_last;
            w_tkeep_next    = w_next_is_last ? r_last_keep : '1;
            if (r_gap != '0) begin
              // Counter is loaded with gap-1 so GAP lasts exactly r_gap cycles.
              w_state_next   = GAP;
              w_gap_cnt_next = r_gap - GAP_ONE;
            end
          end
        end
      end

      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_next = SEND;
        end else begin
          w_gap_cnt_next = r_gap_cnt - GAP_ONE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame parameters and registered stream outputs; reset discards any frame in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_len        <= '0;
      r_beat_idx   <= '0;
      r_data       <= '0;
      r_mode       <= MODE_INC;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_last_keep  <= '0;
      r_tkeep      <= '0;
      r_tlast      <= 1'b0;
      r_zero_pulse <= 1'b0;
    end else begin
      r_len        <= w_len_next;
      r_beat_idx   <= w_beat_idx_next;
      r_data       <= w_data_next;
      r_mode       <= w_mode_next;
      r_gap        <= w_gap_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_last_keep  <= w_last_keep_next;
      r_tkeep      <= w_tkeep_next;
      r_tlast      <= w_tlast_next;
      r_zero_pulse <= w_zero_pulse_next;
    end
  end

  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.m_tvalid   = (r_state == SEND);
  assign bus.m_tdata    = r_data;
  assign bus.m_tkeep    = r_tkeep;
  assign bus.m_tlast    = r_tlast;
  assign busy           = (r_state != IDLE);
  assign zero_len_pulse = r_zero_pulse;

  axis_src_stats u_stats (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .frame_done   (w_frame_done),
    .stall        (w_stall),
    .frames_sent  (frames_sent),
    .stall_cycles (stall_cycles)
  );

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source: drives commands/tready just after each rising edge
// and checks the registered outputs in the same slot.
module tb_axis_frame_source;

  logic        aclk;
  logic        aresetn;
  logic        busy;
  logic        zero_len_pulse;
  logic [31:0] frames_sent;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  axis_frame_source_if #(.DWIDTH(32), .LENWIDTH(16), .GAPWIDTH(4)) bus ();

  axis_frame_source #(.DWIDTH(32), .LENWIDTH(16), .GAPWIDTH(4)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .bus            (bus),
    .busy           (busy),
    .zero_len_pulse (zero_len_pulse),
    .frames_sent    (frames_sent),
    .stall_cycles   (stall_cycles)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] data,
                             input logic [3:0] keep, input logic last);
    $display("beat %s: tvalid=%0b tdata=0x%08h tkeep=%04b tlast=%0b",
             tag, bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast);
    check({tag, ".tvalid"}, 64'(bus.m_tvalid), 64'(1'b1));
    check({tag, ".tdata"},  64'(bus.m_tdata),  64'(data));
    check({tag, ".tkeep"},  64'(bus.m_tkeep),  64'(keep));
    check({tag, ".tlast"},  64'(bus.m_tlast),  64'(last));
  endtask

  task automatic expect_idle_slot(input string tag);
    $display("slot %s: tvalid=%0b busy=%0b", tag, bus.m_tvalid, busy);
    check({tag, ".tvalid"}, 64'(bus.m_tvalid), 64'(1'b0));
  endtask

  task automatic issue(input logic [15:0] len, input logic [31:0] seed, input logic mode,
                       input logic [3:0] gap, input logic [3:0] keep);
    bus.cmd_valid     = 1'b1;
    bus.cmd_len       = len;
    bus.cmd_seed      = seed;
    bus.cmd_mode      = mode;
    bus.cmd_gap       = gap;
    bus.cmd_last_keep = keep;
    $display("cmd: len=%0d seed=0x%08h mode=%0b gap=%0d last_keep=%04b", len, seed, mode, gap, keep);
    check("cmd.ready_before_accept", 64'(bus.cmd_ready), 64'(1'b1));
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    aresetn           = 1'b0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_len       = '0;
    bus.cmd_seed      = '0;
    bus.cmd_mode      = 1'b0;
    bus.cmd_gap       = '0;
    bus.cmd_last_keep = '0;
    bus.m_tready      = 1'b1;
    step();
    step();

    // Reset state
    check("rst.cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
    check("rst.tvalid",    64'(bus.m_tvalid),  64'(1'b0));
    check("rst.tdata",     64'(bus.m_tdata),   64'(0));
    check("rst.tlast",     64'(bus.m_tlast),   64'(1'b0));
    check("rst.busy",      64'(busy),          64'(1'b0));
    check("rst.zero",      64'(zero_len_pulse), 64'(1'b0));
    check("rst.frames",    64'(frames_sent),   64'(0));
    check("rst.stalls",    64'(stall_cycles),  64'(0));
    aresetn = 1'b1;
    step();

    // Frame 1: incrementing, back-to-back, no backpressure
    issue(16'd4, 32'h10, 1'b0, 4'd0, 4'b0111);
    expect_beat("f1.b0", 32'h10, 4'hF, 1'b0);
    check("f1.cmd_ready_busy", 64'(bus.cmd_ready), 64'(1'b0));
    check("f1.busy", 64'(busy), 64'(1'b1));
    step(); expect_beat("f1.b1", 32'h11, 4'hF, 1'b0);
    step(); expect_beat("f1.b2", 32'h12, 4'hF, 1'b0);
    step(); expect_beat("f1.b3", 32'h13, 4'b0111, 1'b1);
    step();
    expect_idle_slot("f1.after");
    check("f1.cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
    check("f1.frames",    64'(frames_sent),   64'(1));
    check("f1.busy_end",  64'(busy),          64'(1'b0));

    // Frame 2: same command, sink stalls 3 cycles on beat 2
    issue(16'd4, 32'h10, 1'b0, 4'd0, 4'b0111);
    expect_beat("f2.b0", 32'h10, 4'hF, 1'b0);
    step(); expect_beat("f2.b1", 32'h11, 4'hF, 1'b0);
    step(); expect_beat("f2.b2", 32'h12, 4'hF, 1'b0);
    bus.m_tready = 1'b0;
    step(); expect_beat("f2.b2_hold1", 32'h12, 4'hF, 1'b0);
    step(); expect_beat("f2.b2_hold2", 32'h12, 4'hF, 1'b0);
    step(); expect_beat("f2.b2_hold3", 32'h12, 4'hF, 1'b0);
    bus.m_tready = 1'b1;
    step(); expect_beat("f2.b3", 32'h13, 4'b0111, 1'b1);
    check("f2.stalls", 64'(stall_cycles), 64'(3));
    step();
    expect_idle_slot("f2.after");
    check("f2.frames", 64'(frames_sent), 64'(2));

    // Frame 3: constant mode with 2-cycle gaps; tready low during a gap must not count as a stall
    issue(16'd3, 32'hA5A5A5A5, 1'b1, 4'd2, 4'b0011);
    expect_beat("f3.b0", 32'hA5A5A5A5, 4'hF, 1'b0);
    step(); expect_idle_slot("f3.gap0a");
    check("f3.busy_in_gap", 64'(busy), 64'(1'b1));
    bus.m_tready = 1'b0;
    step(); expect_idle_slot("f3.gap0b");
    bus.m_tready = 1'b1;
    step(); expect_beat("f3.b1", 32'hA5A5A5A5, 4'hF, 1'b0);
    step(); expect_idle_slot("f3.gap1a");
    step(); expect_idle_slot("f3.gap1b");
    step(); expect_beat("f3.b2", 32'hA5A5A5A5, 4'b0011, 1'b1);
    check("f3.stalls", 64'(stall_cycles), 64'(3));
    step();
    expect_idle_slot("f3.after");
    check("f3.frames", 64'(frames_sent), 64'(3));

    // Zero-length command: one pulse, nothing emitted
    issue(16'd0, 32'h55, 1'b0, 4'd0, 4'hF);
    check("z.pulse",     64'(zero_len_pulse), 64'(1'b1));
    check("z.tvalid",    64'(bus.m_tvalid),   64'(1'b0));
    check("z.cmd_ready", 64'(bus.cmd_ready),  64'(1'b1));
    step();
    $display("zero-len: pulse=%0b frames=%0d", zero_len_pulse, frames_sent);
    check("z.pulse_off", 64'(zero_len_pulse), 64'(1'b0));
    check("z.tvalid2",   64'(bus.m_tvalid),   64'(1'b0));
    check("z.frames",    64'(frames_sent),    64'(3));

    // Data wrap from all-ones to zero
    issue(16'd3, 32'hFFFFFFFE, 1'b0, 4'd0, 4'hF);
    expect_beat("w.b0", 32'hFFFFFFFE, 4'hF, 1'b0);
    step(); expect_beat("w.b1", 32'hFFFFFFFF, 4'hF, 1'b0);
    step(); expect_beat("w.b2", 32'h00000000, 4'hF, 1'b1);
    step();
    check("w.frames", 64'(frames_sent), 64'(4));

    // Reset in the middle of a 10-beat frame
    issue(16'd10, 32'h100, 1'b0, 4'd0, 4'hF);
    expect_beat("r.b0", 32'h100, 4'hF, 1'b0);
    for (int i = 1; i < 6; i++) begin
      step();
      expect_beat($sformatf("r.b%0d", i), 32'h100 + 32'(i), 4'hF, 1'b0);
    end
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    expect_idle_slot("r.after_reset");
    check("r.cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
    check("r.frames",    64'(frames_sent),   64'(0));
    check("r.stalls",    64'(stall_cycles),  64'(0));
    check("r.busy",      64'(busy),          64'(1'b0));
    check("r.tlast",     64'(bus.m_tlast),   64'(1'b0));

    // Fresh frame after reset
    issue(16'd2, 32'h20, 1'b0, 4'd0, 4'b0001);
    expect_beat("p.b0", 32'h20, 4'hF, 1'b0);
    step(); expect_beat("p.b1", 32'h21, 4'b0001, 1'b1);
    step();
    expect_idle_slot("p.after");
    check("p.frames", 64'(frames_sent), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
